// File: rtl/quasi_static_irq_capture.sv
// Debounces a quasi-static status word and turns filtered rising edges into
// sticky, maskable, acknowledgeable per-bit interrupts with overflow tracking.
module quasi_static_irq_capture #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] enable_mask,
  input  logic                  ack_valid,
  input  logic [DATA_WIDTH-1:0] ack_mask,
  output logic [DATA_WIDTH-1:0] irq_out,
  output logic [DATA_WIDTH-1:0] irq_pending,
  output logic [DATA_WIDTH-1:0] overflow,
  output logic [15:0]           change_count
);

  localparam logic [7:0] StableMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0] StableLoad = 8'(STABLE_CYCLES - 1);

  logic [DATA_WIDTH-1:0] sample_q, filtered_q, rise_q, pending_q, irq_q, overflow_q;
  logic [DATA_WIDTH-1:0] filtered_d, rise_d, pending_d, irq_d, overflow_d, ack_clr;
  logic [7:0]            stable_q, stable_d;
  logic [15:0]           count_q, count_d;
  logic                  same, load;

  always_comb begin
    same       = (data_in == sample_q);
    stable_d   = 8'd0;
    load       = 1'b0;
    filtered_d = filtered_q;
    rise_d     = '0;
    count_d    = count_q;

    if (same) begin
      stable_d = (stable_q == StableMax) ? stable_q : stable_q + 8'd1;
      load     = (stable_q == StableLoad) && (sample_q != filtered_q);
    end

    if (load) begin
      filtered_d = sample_q;
      rise_d     = sample_q & ~filtered_q;
      if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end

    // Rise is applied after the ack clear so a coincident ack cannot drop a new event.
    ack_clr    = ack_valid ? ack_mask : '0;
    pending_d  = (pending_q & ~ack_clr) | rise_q;
    overflow_d = overflow_q | (rise_q & pending_q & ~ack_clr);
    irq_d      = pending_d & enable_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q   <= '0;
      filtered_q <= '0;
      rise_q     <= '0;
      stable_q   <= 8'd0;
      pending_q  <= '0;
      irq_q      <= '0;
      overflow_q <= '0;
      count_q    <= 16'd0;
    end else begin
      sample_q   <= data_in;
      filtered_q <= filtered_d;
      rise_q     <= rise_d;
      stable_q   <= stable_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
    end
  end

  assign irq_out      = irq_q;
  assign irq_pending  = pending_q;
  assign overflow     = overflow_q;
  assign change_count = count_q;

endmodule

// File: tb/tb_quasi_static_irq_capture.sv
// Directed bench: a cycle-by-cycle vector trace plus hand-written ack-race and
// mid-operation reset sequences.
module tb_quasi_static_irq_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in, enable_mask, ack_mask;
  logic        ack_valid;
  logic [31:0] irq_out, irq_pending, overflow;
  logic [15:0] change_count;

  int nvec = 0;
  int nerr = 0;

  quasi_static_irq_capture #(
    .DATA_WIDTH   (32),
    .STABLE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .enable_mask (enable_mask),
    .ack_valid   (ack_valid),
    .ack_mask    (ack_mask),
    .irq_out     (irq_out),
    .irq_pending (irq_pending),
    .overflow    (overflow),
    .change_count(change_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [31:0] en;
    logic        av;
    logic [31:0] am;
    logic [31:0] irq;
    logic [31:0] pend;
    logic [31:0] ovf;
    logic [15:0] cnt;
  } vec_t;

  localparam int NumVec = 34;
  vec_t tbl[NumVec];

  function automatic vec_t mk(logic [31:0] d, logic [31:0] en, logic av, logic [31:0] am,
                              logic [31:0] irq, logic [31:0] pend, logic [31:0] ovf,
                              logic [15:0] cnt);
    vec_t v;
    v.d = d; v.en = en; v.av = av; v.am = am;
    v.irq = irq; v.pend = pend; v.ovf = ovf; v.cnt = cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_all(string name, logic [31:0] irq, logic [31:0] pend,
                           logic [31:0] ovf, logic [15:0] cnt);
    check({name, ".irq_out"}, irq_out, irq);
    check({name, ".irq_pending"}, irq_pending, pend);
    check({name, ".overflow"}, overflow, ovf);
    check({name, ".change_count"}, {16'd0, change_count}, {16'd0, cnt});
  endtask

  // Drive inputs for one cycle, then sample just after the rising edge.
  task automatic cyc(logic [31:0] d, logic av, logic [31:0] am);
    data_in   = d;
    ack_valid = av;
    ack_mask  = am;
    @(posedge clk);
    #1;
  endtask

  initial begin
    localparam logic [31:0] All = 32'hFFFF_FFFF;
    //            data      enable  av ack       irq  pend ovf  cnt
    tbl[0]  = mk(32'h0,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    tbl[1]  = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0); // step
    tbl[2]  = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd0);
    tbl[3]  = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1);
    tbl[4]  = mk(32'h5,  All,   0, 32'h0, 32'h5, 32'h5, 32'h0, 16'd1); // 4 cycles after step
    tbl[5]  = mk(32'h5,  All,   0, 32'h5, 32'h5, 32'h5, 32'h0, 16'd1); // ack_mask w/o valid
    tbl[6]  = mk(32'h5,  32'h0, 0, 32'h0, 32'h0, 32'h5, 32'h0, 16'd1); // masked, still pending
    tbl[7]  = mk(32'h5,  32'h0, 1, 32'h5, 32'h0, 32'h0, 32'h0, 16'd1);
    tbl[8]  = mk(32'hD,  32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1); // bit 3 event
    tbl[9]  = mk(32'hD,  32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd1);
    tbl[10] = mk(32'hD,  32'h0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd2);
    tbl[11] = mk(32'hD,  32'h0, 0, 32'h0, 32'h0, 32'h8, 32'h0, 16'd2);
    tbl[12] = mk(32'hD,  32'h8, 0, 32'h0, 32'h8, 32'h8, 32'h0, 16'd2); // unmask
    tbl[13] = mk(32'hD,  32'h8, 1, 32'h8, 32'h0, 32'h0, 32'h0, 16'd2); // ack
    tbl[14] = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd2); // falling bit 3
    tbl[15] = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd2);
    tbl[16] = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd3);
    tbl[17] = mk(32'h5,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd3); // no event on fall
    tbl[18] = mk(32'h7,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd3); // bit 1 rise
    tbl[19] = mk(32'h7,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd3);
    tbl[20] = mk(32'h7,  All,   0, 32'h0, 32'h0, 32'h0, 32'h0, 16'd4);
    tbl[21] = mk(32'h7,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd4);
    tbl[22] = mk(32'h5,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd4); // fall, unacked
    tbl[23] = mk(32'h5,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd4);
    tbl[24] = mk(32'h5,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd5);
    tbl[25] = mk(32'h7,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd5); // second rise
    tbl[26] = mk(32'h7,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd5);
    tbl[27] = mk(32'h7,  All,   0, 32'h0, 32'h2, 32'h2, 32'h0, 16'd6);
    tbl[28] = mk(32'h7,  All,   0, 32'h0, 32'h2, 32'h2, 32'h2, 16'd6); // overflow
    tbl[29] = mk(32'h7,  All,   1, 32'h2, 32'h0, 32'h0, 32'h2, 16'd6); // overflow sticky
    tbl[30] = mk(32'h17, All,   0, 32'h0, 32'h0, 32'h0, 32'h2, 16'd6); // 1-cycle glitch
    tbl[31] = mk(32'h7,  All,   0, 32'h0, 32'h0, 32'h0, 32'h2, 16'd6);
    tbl[32] = mk(32'h7,  All,   0, 32'h0, 32'h0, 32'h0, 32'h2, 16'd6);
    tbl[33] = mk(32'h7,  All,   0, 32'h0, 32'h0, 32'h0, 32'h2, 16'd6);

    rst = 1'b1; data_in = '0; enable_mask = All; ack_valid = 1'b0; ack_mask = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      enable_mask = tbl[i].en;
      cyc(tbl[i].d, tbl[i].av, tbl[i].am);
      check_all($sformatf("vec%0d", i), tbl[i].irq, tbl[i].pend, tbl[i].ovf, tbl[i].cnt);
    end

    // Ack race: the second rise of bit 0 lands in the same cycle as its ack.
    rst = 1'b1;
    cyc(32'h0, 1'b0, 32'h0);
    rst = 1'b0;
    enable_mask = All;
    for (int i = 0; i < 4; i++) cyc(32'h1, 1'b0, 32'h0);
    check_all("race.first", 32'h1, 32'h1, 32'h0, 16'd1);
    for (int i = 0; i < 3; i++) cyc(32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) cyc(32'h1, 1'b0, 32'h0);
    check_all("race.pre", 32'h1, 32'h1, 32'h0, 16'd3);
    cyc(32'h1, 1'b1, 32'h1);
    check_all("race.hit", 32'h1, 32'h1, 32'h0, 16'd3);
    cyc(32'h1, 1'b0, 32'h0);
    check_all("race.after", 32'h1, 32'h1, 32'h0, 16'd3);

    // Build pending=F, overflow=1, then reset while the filter is mid-count.
    for (int i = 0; i < 4; i++) cyc(32'hF, 1'b0, 32'h0);
    check_all("rmid.pendF", 32'hF, 32'hF, 32'h0, 16'd4);
    for (int i = 0; i < 3; i++) cyc(32'hE, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) cyc(32'hF, 1'b0, 32'h0);
    check_all("rmid.ovf", 32'hF, 32'hF, 32'h1, 16'd6);
    cyc(32'h3, 1'b0, 32'h0);
    rst = 1'b1;
    cyc(32'h3, 1'b1, 32'hF);
    check_all("rmid.reset", 32'h0, 32'h0, 32'h0, 16'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(32'h3, 1'b0, 32'h0);
    check_all("rmid.early", 32'h0, 32'h0, 32'h0, 16'd1);
    cyc(32'h3, 1'b0, 32'h0);
    check_all("rmid.irq", 32'h3, 32'h3, 32'h0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
